// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - key pins and conditioned key outputs grouped as one bundle
interface key_debounce_if #(
    parameter int KEYS = 2
);
    localparam int CODE_W = (KEYS > 1) ? $clog2(KEYS) : 1;

    logic [KEYS-1:0]   key;
    logic [KEYS-1:0]   key_state;
    logic [KEYS-1:0]   key_press;
    logic [KEYS-1:0]   key_release;
    logic [CODE_W-1:0] last_code;
    logic              last_valid;

    modport master (
        output key,
        input  key_state, key_press, key_release, last_code, last_valid
    );

    modport slave (
        input  key,
        output key_state, key_press, key_release, last_code, last_valid
    );
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizes and debounces push-buttons into levels and event strobes
module key_debounce #(
    parameter int KEYS            = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    key_debounce_if.slave kif
);
    localparam int               CODE_W    = (KEYS > 1) ? $clog2(KEYS) : 1;
    localparam logic             REL_LEVEL = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} state_t;

    logic [KEYS-1:0]   sync1;
    logic [KEYS-1:0]   sync2;
    logic [KEYS-1:0]   s;
    logic [KEYS-1:0]   held;
    logic [KEYS-1:0]   accept;
    logic [KEYS-1:0]   press_nxt;
    logic [CODE_W-1:0] code_nxt;
    state_t            st  [KEYS];
    logic [CNT_W-1:0]  cnt [KEYS];
    logic [KEYS-1:0]   press_q;
    logic [KEYS-1:0]   release_q;
    logic [CODE_W-1:0] code_q;
    logic              valid_q;

    assign s = REL_LEVEL ? ~sync2 : sync2;

    // Acceptance is decided combinationally so last_code can update in the same cycle as its strobe.
    always_comb begin
        held      = '0;
        accept    = '0;
        press_nxt = '0;
        code_nxt  = '0;
        for (int i = 0; i < KEYS; i++) begin
            held[i]      = (st[i] == PRESSED);
            accept[i]    = (s[i] != held[i]) && (cnt[i] == CNT_LAST);
            press_nxt[i] = accept[i] & s[i];
        end
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (press_nxt[i]) code_nxt = CODE_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= {KEYS{REL_LEVEL}};
            sync2     <= {KEYS{REL_LEVEL}};
            press_q   <= '0;
            release_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            for (int i = 0; i < KEYS; i++) begin
                st[i]  <= RELEASED;
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= kif.key;
            sync2 <= sync1;
            for (int i = 0; i < KEYS; i++) begin
                press_q[i]   <= accept[i] & s[i];
                release_q[i] <= accept[i] & ~s[i];
                case (st[i])
                    RELEASED: begin
                        if (!s[i]) begin
                            cnt[i] <= '0;
                        end else if (accept[i]) begin
                            cnt[i] <= '0;
                            st[i]  <= PRESSED;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (s[i]) begin
                            cnt[i] <= '0;
                        end else if (accept[i]) begin
                            cnt[i] <= '0;
                            st[i]  <= RELEASED;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        cnt[i] <= '0;
                        st[i]  <= RELEASED;
                    end
                endcase
            end
            if (press_nxt != '0) begin
                code_q  <= code_nxt;
                valid_q <= 1'b1;
            end
        end
    end

    assign kif.key_state   = held;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.last_code   = code_q;
    assign kif.last_valid  = valid_q;
endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed self-checking bench for key_debounce
module tb_key_debounce;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    key_debounce_if #(.KEYS(2)) kif ();

    key_debounce #(
        .KEYS(2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(16),
        .ACTIVE_LOW(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kif  (kif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks n edges after a raw change: quiet for n-1 edges, then the expected strobe, then back to quiet.
    task automatic expect_event(input string tag, input int n, input logic [1:0] st_old,
                                input logic [1:0] st_new, input logic [1:0] pr, input logic [1:0] rl);
        for (int k = 1; k < n; k++) begin
            tick();
            check({tag, "_wait_state"}, kif.key_state, st_old);
            check({tag, "_wait_press"}, kif.key_press, 2'b00);
            check({tag, "_wait_rel"}, kif.key_release, 2'b00);
        end
        tick();
        check({tag, "_state"}, kif.key_state, st_new);
        check({tag, "_press"}, kif.key_press, pr);
        check({tag, "_rel"}, kif.key_release, rl);
        tick();
        check({tag, "_after_press"}, kif.key_press, 2'b00);
        check({tag, "_after_rel"}, kif.key_release, 2'b00);
        check({tag, "_after_state"}, kif.key_state, st_new);
    endtask

    task automatic expect_quiet(input string tag, input int n, input logic [1:0] st);
        for (int k = 0; k < n; k++) begin
            tick();
            check({tag, "_state"}, kif.key_state, st);
            check({tag, "_press"}, kif.key_press, 2'b00);
            check({tag, "_rel"}, kif.key_release, 2'b00);
        end
    endtask

    initial begin
        kif.key = 2'b11;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("rst_state", kif.key_state, 2'b00);
            check("rst_press", kif.key_press, 2'b00);
            check("rst_rel", kif.key_release, 2'b00);
            check("rst_code", kif.last_code, 1'b0);
            check("rst_valid", kif.last_valid, 1'b0);
        end

        kif.key = 2'b10;
        expect_event("k0_press", 6, 2'b00, 2'b01, 2'b01, 2'b00);
        check("k0_code", kif.last_code, 1'b0);
        check("k0_valid", kif.last_valid, 1'b1);
        kif.key = 2'b11;
        expect_event("k0_release", 6, 2'b01, 2'b00, 2'b00, 2'b01);
        check("k0_rel_valid", kif.last_valid, 1'b1);

        kif.key = 2'b01;
        tick();
        kif.key = 2'b11;
        tick();
        kif.key = 2'b01;
        tick();
        kif.key = 2'b11;
        tick();
        check("bounce_press_a", kif.key_press, 2'b00);
        kif.key = 2'b01;
        expect_event("bounce", 6, 2'b00, 2'b10, 2'b10, 2'b00);
        check("bounce_code", kif.last_code, 1'b1);
        kif.key = 2'b11;
        expect_event("k1_release", 6, 2'b10, 2'b00, 2'b00, 2'b10);
        check("k1_rel_code", kif.last_code, 1'b1);

        kif.key = 2'b10;
        tick();
        tick();
        tick();
        kif.key = 2'b11;
        expect_quiet("glitch", 10, 2'b00);
        check("glitch_code", kif.last_code, 1'b1);

        kif.key = 2'b00;
        expect_event("both", 6, 2'b00, 2'b11, 2'b11, 2'b00);
        check("both_code", kif.last_code, 1'b0);
        kif.key = 2'b01;
        expect_event("rel0_only", 6, 2'b11, 2'b10, 2'b00, 2'b01);
        check("rel0_code", kif.last_code, 1'b0);

        rst_n = 1'b0;
        tick();
        check("mid_rst_state", kif.key_state, 2'b00);
        check("mid_rst_valid", kif.last_valid, 1'b0);
        check("mid_rst_press", kif.key_press, 2'b00);
        rst_n = 1'b1;
        expect_event("re_press", 6, 2'b00, 2'b10, 2'b10, 2'b00);
        check("re_press_code", kif.last_code, 1'b1);
        check("re_press_valid", kif.last_valid, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
